keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 211 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix, debounces over whole frames, reports single keys.
// Latency: outputs register one cycle after the frame-end tick; a press is accepted after DEBOUNCE_SCANS stable frames.
// Backpressure: none; key_valid is a one-cycle pulse that the consumer must take when it appears.
//
// Ports: clk, rst_n (async active-low); rows[3:0] active-low matrix sense (async to clk);
//        cols[3:0] active-low one-hot column drive; key_code[3:0] = row*4+col of the accepted key;
//        key_valid one-cycle event pulse; key_held level while the accepted key is down.
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat pulses while a key stays held.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1350,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_FIRST   = 32,
    parameter int REPEAT_NEXT    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx;
    logic [3:0]       rows_s1, rows_s2;
    logic [15:0]      map, frame_map;
    logic             tick, frame_end;
    logic [4:0]       n_set;
    logic             single;
    logic [3:0]       single_key;

    state_t     state, state_n;
    logic [3:0] cand, cand_n, cnt, cnt_n, cnt_inc, code_n;
    logic       valid_n, held_n;
    logic       rpt_clr, rpt_step, rpt_due;

    assign tick      = (div == DIV_W'(SCAN_DIV - 1));
    assign frame_end = tick && (col_idx == 2'd3);
    assign cols      = ~(4'b0001 << col_idx);

    // Map including the column sampled this cycle, so frame end classifies all 16 keys at once.
    always_comb begin
        frame_map = map;
        for (int r = 0; r < 4; r++) begin
            frame_map[{2'(r), col_idx}] = ~rows_s2[r];
        end
    end

    always_comb begin
        n_set      = '0;
        single_key = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_map[i]) begin
                n_set      = n_set + 5'd1;
                single_key = 4'(i);
            end
        end
        // Two or more keys may be ghosting; only a lone key is ever reported.
        single = (n_set == 5'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_s1 <= 4'hF;
            rows_s2 <= 4'hF;
            div     <= '0;
            col_idx <= '0;
            map     <= '0;
        end else begin
            rows_s1 <= rows;
            rows_s2 <= rows_s1;
            if (tick) begin
                div     <= '0;
                col_idx <= col_idx + 2'd1;
                map     <= frame_map;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        code_n   = key_code;
        valid_n  = 1'b0;
        held_n   = key_held;
        rpt_clr  = 1'b0;
        rpt_step = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (single) begin
                        if (DEB == 4'd1) begin
                            code_n  = single_key;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            state_n = PRESSED;
                            rpt_clr = 1'b1;
                        end else begin
                            cand_n  = single_key;
                            cnt_n   = 4'd1;
                            state_n = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (single && single_key == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DEB) begin
                            code_n  = cand;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            state_n = PRESSED;
                            rpt_clr = 1'b1;
                        end
                    end else if (single) begin
                        cand_n = single_key;
                        cnt_n  = 4'd1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                PRESSED: begin
                    if (single && single_key == key_code) begin
                        rpt_step = 1'b1;
                        valid_n  = rpt_due;
                    end else if (DEB == 4'd1) begin
                        held_n  = 1'b0;
                        state_n = IDLE;
                        rpt_clr = 1'b1;
                    end else begin
                        cnt_n   = 4'd1;
                        state_n = RELEASE;
                        rpt_clr = 1'b1;
                    end
                end
                RELEASE: begin
                    // Key reappearing is contact bounce: resume the press silently.
                    if (single && single_key == key_code) begin
                        state_n = PRESSED;
                        rpt_clr = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DEB) begin
                            held_n  = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Frames of steady hold since accept (or since the last repeat); first gap is longer.
    logic [15:0] rpt_cnt;
    logic        rpt_first;

    assign rpt_due = ((rpt_cnt + 16'd1) == (rpt_first ? 16'(REPEAT_FIRST) : 16'(REPEAT_NEXT)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_clr) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_step) begin
            if (rpt_due) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_rpt;
    assign rpt_due    = 1'b0;
    assign unused_rpt = rpt_clr | rpt_step;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int RF       = 3;
    localparam int RN       = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rows, cols, key_code;
    logic       key_valid, key_held;
    logic [15:0] keys = '0;

    int checks = 0;
    int passed = 0;

    // Frame-level reference: held flag, accepted code, candidate, run length, repeat progress.
    bit m_held, m_pulse;
    int m_code, m_cand, m_acc, m_rep, m_target;

    // What the DUT showed during the last frame.
    int         o_early;
    logic       o_valid, o_held;
    logic [3:0] o_code;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB), .REPEAT_FIRST(RF), .REPEAT_NEXT(RN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rows(rows), .cols(cols),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", passed, checks);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_held = 0; m_pulse = 0; m_code = 0; m_cand = 0; m_acc = 0; m_rep = 0; m_target = RF;
    endtask

    task automatic model_step(input logic [15:0] m);
        int o;
        o = -1;
        if ($countones(m) == 1)
            for (int i = 0; i < 16; i++) if (m[i]) o = i;
        m_pulse = 0;
        if (!m_held) begin
            if (o < 0) m_acc = 0;
            else if (o == m_cand && m_acc > 0) m_acc++;
            else begin m_cand = o; m_acc = 1; end
            if (m_acc >= DEB) begin
                m_held = 1; m_code = m_cand; m_pulse = 1; m_acc = 0; m_rep = 0; m_target = RF;
            end
        end else if (o == m_code) begin
            if (m_acc > 0) begin m_acc = 0; m_rep = 0; m_target = RF; end
            else begin
                m_rep++;
`ifdef KEYPAD_REPEAT_EN
                if (m_rep == m_target) begin m_pulse = 1; m_rep = 0; m_target = RN; end
`endif
            end
        end else begin
            m_acc++;
            if (m_acc >= DEB) begin m_held = 0; m_acc = 0; end
        end
    endtask

    // Drive one frame-aligned frame of key state and record what the DUT did.
    task automatic run_frame(input logic [15:0] m);
        keys = m; o_early = 0; o_valid = 0;
        for (int i = 1; i <= FRAME; i++) begin
            @(posedge clk); #1;
            if (i < FRAME) begin
                if (key_valid) o_early++;
            end else begin
                o_valid = key_valid; o_held = key_held; o_code = key_code;
            end
        end
        model_step(m);
    endtask

    task automatic test_reset();
        logic [3:0] exp_cols;
        keys = '0; rst_n = 0; model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cols, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 2'b00})
            $display("FAIL reset_values: cols=%b code=%h valid=%b held=%b, want 1110 0 0 0", cols, key_code, key_valid, key_held);
        else passed++;
        rst_n = 1;
        for (int i = 1; i <= FRAME; i++) begin
            @(posedge clk); #1;
            exp_cols = ~(4'b0001 << ((i / SCAN_DIV) % 4));
            checks++;
            if (cols !== exp_cols) $display("FAIL reset_col_step cycle %0d: cols=%b want %b", i, cols, exp_cols);
            else passed++;
        end
        model_step(16'h0);
    endtask

    task automatic test_clean_press();
        logic [15:0] seq[$];
        int pulses = 0, first = -1;
        repeat (10) seq.push_back(16'h0040);
        repeat (4) seq.push_back(16'h0000);
        foreach (seq[f]) begin
            run_frame(seq[f]);
            checks++;
            if (o_valid !== m_pulse || o_early != 0) $display("FAIL clean_valid f%0d: valid=%b early=%0d want %b 0", f, o_valid, o_early, m_pulse);
            else passed++;
            checks++;
            if (o_held !== m_held) $display("FAIL clean_held f%0d: held=%b want %b", f, o_held, m_held);
            else passed++;
            checks++;
            if (o_code !== 4'(m_code)) $display("FAIL clean_code f%0d: code=%0d want %0d", f, o_code, m_code);
            else passed++;
            if (o_valid) begin pulses++; if (first < 0) first = f; end
            if (f == 12) begin
                checks++;
                if (o_held !== 1'b0) $display("FAIL clean_release_latency: held=%b want 0", o_held);
                else passed++;
            end
        end
        checks++;
        if (pulses != 1 || first < 0 || first > 2)
            $display("FAIL clean_pulse: pulses=%0d first_frame=%0d want 1 pulse within frame 2", pulses, first);
        else passed++;
    endtask

    task automatic test_bounce();
        int pulses = 0, helds = 0;
        for (int f = 0; f < 8; f++) begin
            run_frame((f % 2 == 0) ? 16'h0200 : 16'h0000);
            if (o_valid || o_early != 0) pulses++;
            if (o_held) helds++;
            checks++;
            if (o_valid !== m_pulse || o_held !== m_held) $display("FAIL bounce_model f%0d: valid=%b held=%b want %b %b", f, o_valid, o_held, m_pulse, m_held);
            else passed++;
        end
        checks++;
        if (pulses != 0 || helds != 0) $display("FAIL bounce_reject: pulses=%0d held_frames=%0d want 0 0", pulses, helds);
        else passed++;
    endtask

    task automatic test_ghost();
        logic [15:0] seq[$];
        int ghost_pulses = 0, good_pulses = 0;
        repeat (6) seq.push_back(16'h0021);
        repeat (4) seq.push_back(16'h0001);
        repeat (3) seq.push_back(16'h0000);
        foreach (seq[f]) begin
            run_frame(seq[f]);
            if (o_valid) begin
                if (f < 6) ghost_pulses++;
                else begin
                    good_pulses++;
                    checks++;
                    if (o_code !== 4'd0) $display("FAIL ghost_code f%0d: code=%0d want 0", f, o_code);
                    else passed++;
                end
            end
            checks++;
            if (o_valid !== m_pulse || o_early != 0 || o_held !== m_held)
                $display("FAIL ghost_model f%0d: valid=%b early=%0d held=%b want %b 0 %b", f, o_valid, o_early, o_held, m_pulse, m_held);
            else passed++;
        end
        checks++;
        if (ghost_pulses != 0 || good_pulses != 1) $display("FAIL ghost_reject: ghost=%0d single=%0d want 0 1", ghost_pulses, good_pulses);
        else passed++;
    endtask

    task automatic test_release_bounce();
        logic [15:0] seq[$];
        int pulses = 0;
        repeat (3) seq.push_back(16'h0008);
        seq.push_back(16'h0000);
        repeat (3) seq.push_back(16'h0008);
        repeat (3) seq.push_back(16'h0000);
        foreach (seq[f]) begin
            run_frame(seq[f]);
            if (o_valid) pulses++;
            checks++;
            if (o_valid !== m_pulse || o_held !== m_held || o_code !== 4'(m_code))
                $display("FAIL relbounce_model f%0d: valid=%b held=%b code=%0d want %b %b %0d", f, o_valid, o_held, o_code, m_pulse, m_held, m_code);
            else passed++;
            if (f >= 1 && f <= 7) begin
                checks++;
                if (o_held !== 1'b1) $display("FAIL relbounce_held f%0d: held=%b want 1", f, o_held);
                else passed++;
            end
        end
        checks++;
        if (pulses != 1 || o_held !== 1'b0) $display("FAIL relbounce_end: pulses=%0d held=%b want 1 0", pulses, o_held);
        else passed++;
    endtask

    task automatic test_repeat();
        int pulses = 0, first = -1, last = -1, exp_n, exp_last;
`ifdef KEYPAD_REPEAT_EN
        exp_n = 5; exp_last = 10;
`else
        exp_n = 1; exp_last = 1;
`endif
        for (int f = 0; f < 15; f++) begin
            run_frame((f < 12) ? 16'h8000 : 16'h0000);
            if (o_valid) begin
                pulses++; last = f; if (first < 0) first = f;
                checks++;
                if (o_code !== 4'd15) $display("FAIL repeat_code f%0d: code=%0d want 15", f, o_code);
                else passed++;
            end
            checks++;
            if (o_valid !== m_pulse || o_early != 0 || o_held !== m_held)
                $display("FAIL repeat_model f%0d: valid=%b early=%0d held=%b want %b 0 %b", f, o_valid, o_early, o_held, m_pulse, m_held);
            else passed++;
        end
        checks++;
        if (pulses != exp_n || first != 1 || last != exp_last)
            $display("FAIL repeat_count: pulses=%0d first=%0d last=%0d want %0d 1 %0d", pulses, first, last, exp_n, exp_last);
        else passed++;
    endtask

    task automatic test_reset_mid();
        repeat (3) run_frame(16'h0040);
        keys = 16'h0040;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        checks++;
        if ({cols, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 2'b00})
            $display("FAIL reset_mid: cols=%b code=%h valid=%b held=%b, want 1110 0 0 0", cols, key_code, key_valid, key_held);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1; model_reset();
        for (int f = 0; f < 8; f++) begin
            run_frame((f < 4) ? 16'h0040 : 16'h0000);
            checks++;
            if (o_valid !== m_pulse || o_early != 0 || o_held !== m_held || o_code !== 4'(m_code))
                $display("FAIL reset_mid_model f%0d: valid=%b early=%0d held=%b code=%0d want %b 0 %b %0d", f, o_valid, o_early, o_held, o_code, m_pulse, m_held, m_code);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [15:0] cur;
        int k = 0, sel, len, f = 0;
        for (int s = 0; s < 60; s++) begin
            sel = $urandom_range(0, 9);
            len = $urandom_range(1, 4);
            if (sel < 3) cur = 16'h0000;
            else if (sel < 8) begin
                if ($urandom_range(0, 9) < 3) k = $urandom_range(0, 15);
                cur = 16'h0001 << k;
            end else cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            repeat (len) begin
                run_frame(cur);
                checks++;
                if (o_valid !== m_pulse || o_early != 0 || o_held !== m_held || o_code !== 4'(m_code))
                    $display("FAIL random f%0d keys=%h: valid=%b early=%0d held=%b code=%0d want %b 0 %b %0d", f, cur, o_valid, o_early, o_held, o_code, m_pulse, m_held, m_code);
                else passed++;
                f++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_ghost();
        test_release_bounce();
        test_repeat();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
